cordic_hyp_rot_exp: RTL and testbench
=====================================

// Module: cordic_hyp_rot_exp
// PURPOSE
//  Iterative hyperbolic CORDIC in rotation mode: drives z to zero and produces cosh(z), sinh(z), exp(z).
//  Inverse companion of the hyperbolic vectoring/log datapath. Shares its Q8.24 angle format and atanh table.
//  Single micro-rotation engine, one rotation per clock. Valid/ready on input and on output.
// PARAMETERS
//  WD      32  x/y word is 2*WD bits signed, WD fractional bits (1.0 = 1<<WD)
//  N_ITER  24  last shift index, legal 14..25; indices 4 and 13 are executed twice
// PORTS
//  i_clk     in   1      clock, all state on rising edge
//  i_arstn   in   1      asynchronous active-low reset
//  i_valid   in   1      input request
//  o_ready   out  1      block can accept; high only in IDLE
//  i_z       in   32     signed Q8.24 argument
//  o_valid   out  1      result available; high only in DONE
//  i_ready   in   1      consumer accepts result
//  o_cosh    out  2*WD   signed Q(WD).WD cosh(z)
//  o_sinh    out  2*WD   signed Q(WD).WD sinh(z)
//  o_exp     out  2*WD   signed Q(WD).WD exp(z) = cosh+sinh
//  o_clip    out  1      input was saturated (CORDIC_EXP_SAT_EN only; otherwise tied 0)
// BEHAVIOUR
//  Reset: FSM=IDLE, so o_ready=1. o_valid=0; o_cosh, o_sinh, o_exp, o_clip = 0; x, y, z, and iter registers = 0.
//  FSM: IDLE -> RUN -> DONE -> IDLE. o_ready=(state==IDLE), o_valid=(state==DONE).
//  IDLE: on i_valid, load x=X_INIT, y=0, z=i_z, iter=1, rep=0, then go to RUN.
//   X_INIT=round(2^WD*1.2074970678), i.e. 1/Kh for the repeat schedule.
//  RUN: one rotation per clock. d=+1 if z>=0 (z[31]==0), else -1.
//   x'=x+d*(y>>>iter); y'=y+d*(x>>>iter); z'=z-d*ATANH[iter]. Arithmetic shifts; 2*WD wrap, no saturation.
//   iter schedule: 1,2,3,4,4,5..13,13,14..N_ITER. At iter 4 or 13 with rep=0: set rep=1 and keep iter.
//   Otherwise: clear rep and increment iter. At iter==N_ITER after its last pass: go to DONE.
//   In the same edge, register o_cosh=x', o_sinh=y', o_exp=x'+y'.
//  ATANH ROM: atanh(2^-i) in Q8.24, round-to-nearest.
//   1:008C9F54  2:004162BC  3:00202B12  4:00100559  5:000800AB  6:00040015  7:00020003.
//   i>=8: 2^(24-i). Index 25: 00000001. Out-of-range index reads 0.
//  Latency: N_ITER+2 rotation cycles (26 at default). o_valid rises N_ITER+2 clocks after the accepting edge.
//  DONE: outputs held stable while i_ready=0 (back-pressure). On i_ready=1, go to IDLE.
//   New requests are not accepted in the DONE->IDLE cycle: o_ready=0 there, so i_valid is ignored.
//  i_valid while RUN or DONE is ignored. The upstream block holds it until o_ready.
//  Convergence range: |z| <= ZMAX = 32'h011E0000 (~1.1172). Results outside it are unspecified unless SAT_EN.
//  Reset asserted mid-RUN or DONE: immediate return to reset state. The partial result is discarded and no o_valid pulse occurs.
//  o_exp is always >0 for in-range z. Integer headroom is WD-1 bits, ample for exp(1.12)~3.06.
// CONFIGURATION
//  CORDIC_EXP_SAT_EN defined:
//   On IDLE capture, z>ZMAX loads ZMAX and z<-ZMAX loads -ZMAX. o_clip is registered with the result and held through DONE.
//   o_clip clears on the next acceptance.
//  CORDIC_EXP_SAT_EN undefined:
//   i_z is loaded unmodified. o_clip is a constant 0. No comparator logic is synthesised.
// TESTING (tolerance |err| <= 2^-20 vs. real model, WD=32, N_ITER=24)
//  Reset, then z=0x00000000 -> after 26 clk o_valid=1. cosh=1.0 (0x1_00000000), sinh~0, exp~1.0.
//  z=0x00800000 (0.5) -> cosh=1.127626, sinh=0.521095, exp=1.648721. o_ready low for the whole RUN.
//  z=0xFF000000 (-1.0) -> cosh=1.543081, sinh=-1.175201, exp=0.367879. Exercises d=-1 and both repeats.
//  Back-pressure: i_ready=0 for 10 clk in DONE with i_valid=1 and new z.
//   Required: outputs unchanged, o_valid stays 1, the new z is not accepted until IDLE.
//  Reset pulse at RUN cycle 10:
//   Required: o_valid=0 and data=0 at once, o_ready=1 after release, and the next z=0.5 gives the correct result.
//  SAT_EN: z=0x02000000 (2.0) -> o_clip=1, exp=exp(1.1171875)=3.0563. Without macro: o_clip=0.

Source files
------------

// File: rtl/cordic_hyp_rot_exp.sv
// rtl/cordic_hyp_rot_exp.sv - iterative hyperbolic CORDIC rotation: cosh, sinh, exp of a Q8.24 angle
// Optional input clamp to the convergence range: CORDIC_EXP_SAT_EN.
module cordic_hyp_rot_exp #(
   parameter int WD     = 32,
   parameter int N_ITER = 24
) (
   input  logic                 i_clk,
   input  logic                 i_arstn,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [31:0]          i_z,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic signed [2*WD-1:0] o_cosh,
   output logic signed [2*WD-1:0] o_sinh,
   output logic signed [2*WD-1:0] o_exp,
   output logic                 o_clip
);

   localparam int XW = 2*WD;
   // 1/Kh for the 4/13 repeat schedule, held in Q32.32 and rescaled to WD fractional bits
   localparam logic [63:0] X_INIT_Q32 = 64'h0000_0001_351E_8720;
   localparam logic signed [XW-1:0] X_INIT = XW'({X_INIT_Q32, 32'b0} >> (64 - WD));
   localparam logic [4:0] LAST_ITER = 5'(N_ITER);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state;
   logic signed [XW-1:0]  x, y;
   logic [31:0]           z;
   logic [4:0]            iter;
   logic                  rep;

   logic signed [XW-1:0]  x_sh, y_sh, x_nx, y_nx;
   logic [31:0]           ang, z_nx, z_load;
   logic                  d_pos, rep_now, last;

   function automatic logic [31:0] atanh_rom(input logic [4:0] i);
      logic [31:0] r;
      case (i)
         5'd1:    r = 32'h008C9F54;
         5'd2:    r = 32'h004162BC;
         5'd3:    r = 32'h00202B12;
         5'd4:    r = 32'h00100559;
         5'd5:    r = 32'h000800AB;
         5'd6:    r = 32'h00040015;
         5'd7:    r = 32'h00020003;
         5'd25:   r = 32'h00000001;
         default: begin
            if (i >= 5'd8 && i <= 5'd24) r = 32'd1 << (5'd24 - i);
            else                         r = 32'd0;
         end
      endcase
      return r;
   endfunction

   always_comb begin
      d_pos   = ~z[31];
      x_sh    = x >>> iter;
      y_sh    = y >>> iter;
      ang     = atanh_rom(iter);
      x_nx    = d_pos ? (x + y_sh) : (x - y_sh);
      y_nx    = d_pos ? (y + x_sh) : (y - x_sh);
      z_nx    = d_pos ? (z - ang) : (z + ang);
      rep_now = (iter == 5'd4 || iter == 5'd13) && !rep;
      last    = (iter == LAST_ITER) && !rep_now;
   end

`ifdef CORDIC_EXP_SAT_EN
   localparam logic signed [31:0] ZMAX     = 32'sh011E0000;
   localparam logic signed [31:0] ZMAX_NEG = -ZMAX;
   logic z_hi, z_lo, clip_load, clip_pend;

   always_comb begin
      z_hi      = $signed(i_z) > ZMAX;
      z_lo      = $signed(i_z) < ZMAX_NEG;
      clip_load = z_hi | z_lo;
      z_load    = z_hi ? ZMAX : (z_lo ? ZMAX_NEG : i_z);
   end

   // The clip flag travels with the request and is published together with the result
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         clip_pend <= 1'b0;
         o_clip    <= 1'b0;
      end else if (state == S_IDLE && i_valid) begin
         clip_pend <= clip_load;
         o_clip    <= 1'b0;
      end else if (state == S_RUN && last) begin
         o_clip    <= clip_pend;
      end
   end
`else
   assign z_load = i_z;
   assign o_clip = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         state   <= S_IDLE;
         o_ready <= 1'b1;
         o_valid <= 1'b0;
         x       <= '0;
         y       <= '0;
         z       <= '0;
         iter    <= '0;
         rep     <= 1'b0;
         o_cosh  <= '0;
         o_sinh  <= '0;
         o_exp   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  x       <= X_INIT;
                  y       <= '0;
                  z       <= z_load;
                  iter    <= 5'd1;
                  rep     <= 1'b0;
                  state   <= S_RUN;
                  o_ready <= 1'b0;
               end
            end
            S_RUN: begin
               x <= x_nx;
               y <= y_nx;
               z <= z_nx;
               if (rep_now) begin
                  rep <= 1'b1;
               end else begin
                  rep <= 1'b0;
                  if (!last) iter <= iter + 5'd1;
               end
               if (last) begin
                  state   <= S_DONE;
                  o_valid <= 1'b1;
                  o_cosh  <= x_nx;
                  o_sinh  <= y_nx;
                  o_exp   <= x_nx + y_nx;
               end
            end
            S_DONE: begin
               // Leaving DONE lands in IDLE with o_ready rising only after this edge
               if (i_ready) begin
                  state   <= S_IDLE;
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               o_ready <= 1'b1;
               o_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_hyp_rot_exp.sv
// tb/tb_cordic_hyp_rot_exp.sv - directed self-checking bench for cordic_hyp_rot_exp
module tb_cordic_hyp_rot_exp;

   logic               i_clk   = 1'b0;
   logic               i_arstn = 1'b1;
   logic               i_valid = 1'b0;
   logic               i_ready = 1'b0;
   logic [31:0]        i_z     = '0;
   logic               o_ready, o_valid, o_clip;
   logic signed [63:0] o_cosh, o_sinh, o_exp;

   int n_checks = 0;
   int n_fail   = 0;

   localparam longint TOL = 64'd4096;

   cordic_hyp_rot_exp #(.WD(32), .N_ITER(24)) dut (
      .i_clk   (i_clk),
      .i_arstn (i_arstn),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_z     (i_z),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_cosh  (o_cosh),
      .o_sinh  (o_sinh),
      .o_exp   (o_exp),
      .o_clip  (o_clip)
   );

   always #5 i_clk = ~i_clk;

   function automatic longint q32(input real r);
      return longint'(r * 4294967296.0);
   endfunction

   task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
      longint diff;
      diff = obs - exp;
      if (diff < 0) diff = -diff;
      n_checks++;
      if (diff > tol) begin
         n_fail++;
         $display("FAIL %s obs=%0d exp=%0d tol=%0d", tag, obs, exp, tol);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] z);
      i_valid = 1'b1;
      i_z     = z;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat, output int rdy_hi);
      lat    = 0;
      rdy_hi = 0;
      while (!o_valid && lat < 100) begin
         if (o_ready) rdy_hi++;
         tick();
         lat++;
      end
      if (!o_valid) check_val("timeout", 0, 1, 0);
   endtask

   task automatic pop;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
   endtask

   initial begin
      int     lat, rh, changed, vdrop, rdy_seen;
      longint hold_c, hold_s, hold_e;

      #1 i_arstn = 1'b0;
      repeat (3) tick();
      check_val("rst_ready", o_ready, 1, 0);
      check_val("rst_valid", o_valid, 0, 0);
      check_val("rst_cosh",  o_cosh,  0, 0);
      check_val("rst_sinh",  o_sinh,  0, 0);
      check_val("rst_exp",   o_exp,   0, 0);
      check_val("rst_clip",  o_clip,  0, 0);
      i_arstn = 1'b1;
      tick();

      // z = 0
      issue(32'h00000000);
      wait_valid(lat, rh);
      check_val("z0_latency", lat, 26, 0);
      check_val("z0_ready_in_run", rh, 0, 0);
      check_val("z0_cosh", o_cosh, q32(1.0), TOL);
      check_val("z0_sinh", o_sinh, 0, TOL);
      check_val("z0_exp",  o_exp,  q32(1.0), TOL);
      check_val("z0_clip", o_clip, 0, 0);
      pop();
      check_val("pop_ready", o_ready, 1, 0);
      check_val("pop_valid", o_valid, 0, 0);

      // z = 0.5
      issue(32'h00800000);
      wait_valid(lat, rh);
      check_val("zh_ready_in_run", rh, 0, 0);
      check_val("zh_cosh", o_cosh, q32(1.1276259652063807), TOL);
      check_val("zh_sinh", o_sinh, q32(0.5210953054937474), TOL);
      check_val("zh_exp",  o_exp,  q32(1.6487212707001282), TOL);
      pop();

      // z = -1.0
      issue(32'hFF000000);
      wait_valid(lat, rh);
      check_val("zm_latency", lat, 26, 0);
      check_val("zm_cosh", o_cosh, q32(1.5430806348152437), TOL);
      check_val("zm_sinh", o_sinh, q32(-1.1752011936438014), TOL);
      check_val("zm_exp",  o_exp,  q32(0.36787944117144233), TOL);

      // back-pressure with a new request waiting
      hold_c   = o_cosh;
      hold_s   = o_sinh;
      hold_e   = o_exp;
      changed  = 0;
      vdrop    = 0;
      rdy_seen = 0;
      i_valid  = 1'b1;
      i_z      = 32'h00800000;
      repeat (10) begin
         tick();
         if (o_cosh != hold_c || o_sinh != hold_s || o_exp != hold_e) changed++;
         if (!o_valid) vdrop++;
         if (o_ready) rdy_seen++;
      end
      check_val("bp_data_changed", changed, 0, 0);
      check_val("bp_valid_drop", vdrop, 0, 0);
      check_val("bp_ready_seen", rdy_seen, 0, 0);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check_val("bp_idle_ready", o_ready, 1, 0);
      check_val("bp_idle_valid", o_valid, 0, 0);
      tick();
      i_valid = 1'b0;
      wait_valid(lat, rh);
      check_val("bp_next_latency", lat, 26, 0);
      check_val("bp_next_exp", o_exp, q32(1.6487212707001282), TOL);
      pop();

      // reset pulse mid-run
      issue(32'h00800000);
      repeat (10) tick();
      i_arstn = 1'b0;
      #1;
      check_val("mr_valid", o_valid, 0, 0);
      check_val("mr_cosh",  o_cosh,  0, 0);
      check_val("mr_exp",   o_exp,   0, 0);
      tick();
      i_arstn = 1'b1;
      tick();
      check_val("mr_ready", o_ready, 1, 0);
      check_val("mr_no_valid", o_valid, 0, 0);
      issue(32'h00800000);
      wait_valid(lat, rh);
      check_val("mr_cosh_after", o_cosh, q32(1.1276259652063807), TOL);
      check_val("mr_sinh_after", o_sinh, q32(0.5210953054937474), TOL);
      check_val("mr_exp_after",  o_exp,  q32(1.6487212707001282), TOL);
      pop();

      // out-of-range argument
      issue(32'h02000000);
      wait_valid(lat, rh);
`ifdef CORDIC_EXP_SAT_EN
      check_val("sat_clip", o_clip, 1, 0);
      check_val("sat_exp",  o_exp,  q32(3.05624641), TOL);
      pop();
      check_val("sat_clip_held_idle", o_clip, 1, 0);
      issue(32'h00000000);
      check_val("sat_clip_cleared", o_clip, 0, 0);
      wait_valid(lat, rh);
      check_val("sat_after_exp", o_exp, q32(1.0), TOL);
      pop();
`else
      check_val("nosat_clip", o_clip, 0, 0);
      pop();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
